// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - VGA/CPU arbiter for one synchronous memory port (optional ARB_STARVE_GUARD_EN)
// VGA has priority; ARB_STARVE_GUARD_EN lets a CPU that has waited STARVE_MAX cycles win once.
module mem_port_arbiter #(
    parameter int DATA       = 18,
    parameter int ADDR       = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic            CLK,
    input  logic            CLR_N,
    input  logic            vga_req,
    input  logic [ADDR-1:0] vga_addr,
    output logic            vga_gnt,
    output logic            vga_rvalid,
    output logic [DATA-1:0] vga_rdata,
    input  logic            cpu_req,
    input  logic            cpu_wr,
    input  logic [ADDR-1:0] cpu_addr,
    input  logic [DATA-1:0] cpu_din,
    output logic            cpu_gnt,
    output logic            cpu_rvalid,
    output logic [DATA-1:0] cpu_rdata,
    output logic            m_wr,
    output logic [ADDR-1:0] m_addr,
    output logic [DATA-1:0] m_din,
    input  logic [DATA-1:0] m_dout
);

    typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_CPU_RD} owner_t;

    owner_t          owner_q;
    owner_t          owner_d;
    logic            vga_win;
    logic            cpu_win;
    logic            starve_hit;
    logic [ADDR-1:0] addr_q;
    logic [DATA-1:0] din_q;
    logic [DATA-1:0] vga_rdata_q;
    logic [DATA-1:0] cpu_rdata_q;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_cnt;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            starve_cnt <= '0;
        end else if (!cpu_req || cpu_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    assign starve_hit = (starve_cnt == CW'(STARVE_MAX));
`else
    assign starve_hit = 1'b0;
`endif

    // Grants are gated by reset so nothing reaches the memory while CLR_N is low.
    always_comb begin
        vga_win = CLR_N && vga_req && !(cpu_req && starve_hit);
        cpu_win = CLR_N && cpu_req && !vga_win;
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (vga_win) begin
            owner_d = OWN_VGA;
        end else if (cpu_win && !cpu_wr) begin
            owner_d = OWN_CPU_RD;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            addr_q      <= '0;
            din_q       <= '0;
            vga_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            if (vga_win) begin
                addr_q <= vga_addr;
            end else if (cpu_win) begin
                addr_q <= cpu_addr;
                din_q  <= cpu_din;
            end
            if (owner_q == OWN_VGA) begin
                vga_rdata_q <= m_dout;
            end
            if (owner_q == OWN_CPU_RD) begin
                cpu_rdata_q <= m_dout;
            end
        end
    end

    // Read data is passed straight from the memory in the rvalid cycle, then held.
    always_comb begin
        vga_gnt    = vga_win;
        cpu_gnt    = cpu_win;
        m_wr       = cpu_win && cpu_wr;
        m_addr     = addr_q;
        m_din      = din_q;
        if (vga_win) begin
            m_addr = vga_addr;
        end else if (cpu_win) begin
            m_addr = cpu_addr;
            m_din  = cpu_din;
        end
        vga_rvalid = (owner_q == OWN_VGA);
        cpu_rvalid = (owner_q == OWN_CPU_RD);
        vga_rdata  = vga_rvalid ? m_dout : vga_rdata_q;
        cpu_rdata  = cpu_rvalid ? m_dout : cpu_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter with a 1-cycle synchronous memory
module tb_mem_port_arbiter;

    logic        CLK;
    logic        CLR_N;
    logic        vga_req;
    logic [13:0] vga_addr;
    logic        vga_gnt;
    logic        vga_rvalid;
    logic [17:0] vga_rdata;
    logic        cpu_req;
    logic        cpu_wr;
    logic [13:0] cpu_addr;
    logic [17:0] cpu_din;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [17:0] cpu_rdata;
    logic        m_wr;
    logic [13:0] m_addr;
    logic [17:0] m_din;
    logic [17:0] m_dout;

    logic [17:0] mem [0:16383];
    logic [17:0] vdat [0:3];

    int n_cmp = 0;
    int n_err = 0;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
    localparam int NCYC  = 10;
`else
    localparam bit GUARD = 1'b0;
    localparam int NCYC  = 32;
`endif

    mem_port_arbiter #(.DATA(18), .ADDR(14), .STARVE_MAX(4)) dut (
        .CLK(CLK), .CLR_N(CLR_N),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .m_wr(m_wr), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (m_wr) mem[m_addr] <= m_din;
        m_dout <= mem[m_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_preload(input logic [13:0] a, input logic [17:0] d);
        @(negedge CLK);
        vga_req  = 1'b0;
        cpu_req  = 1'b1;
        cpu_wr   = 1'b1;
        cpu_addr = a;
        cpu_din  = d;
    endtask

    initial begin
        logic exp_c;
        vdat[0] = 18'h1A001;
        vdat[1] = 18'h2B002;
        vdat[2] = 18'h3C003;
        vdat[3] = 18'h0D004;
        CLR_N = 1'b0; vga_req = 1'b0; vga_addr = '0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = '0;

        // reset state
        @(negedge CLK); #1;
        chk("rst_vga_gnt", vga_gnt, 0);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_m_wr", m_wr, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_din", m_din, 0);
        chk("rst_vga_rvalid", vga_rvalid, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_vga_rdata", vga_rdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);

        @(negedge CLK);
        CLR_N = 1'b1;
        for (int i = 0; i < 4; i++) cpu_preload(14'(i), vdat[i]);
        cpu_preload(14'h0100, 18'h3C3C3);
        cpu_preload(14'h0020, 18'h01234);
        cpu_preload(14'h0030, 18'h0BEEF);
        @(negedge CLK);
        cpu_req = 1'b0; cpu_wr = 1'b0;
        #1 chk("pre_cpu_rvalid", cpu_rvalid, 0);

        // CPU write then read back
        @(negedge CLK);
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 14'h0010; cpu_din = 18'h2A5A5;
        #1;
        chk("wr_cpu_gnt", cpu_gnt, 1);
        chk("wr_vga_gnt", vga_gnt, 0);
        chk("wr_m_wr", m_wr, 1);
        chk("wr_m_addr", m_addr, 14'h0010);
        chk("wr_m_din", m_din, 18'h2A5A5);
        @(negedge CLK);
        cpu_wr = 1'b0;
        #1;
        chk("rd_cpu_gnt", cpu_gnt, 1);
        chk("rd_m_wr", m_wr, 0);
        chk("wr_no_rvalid", cpu_rvalid, 0);
        @(negedge CLK);
        cpu_req = 1'b0;
        #1;
        chk("rd_cpu_rvalid", cpu_rvalid, 1);
        chk("rd_cpu_rdata", cpu_rdata, 18'h2A5A5);
        chk("idle_cpu_gnt", cpu_gnt, 0);
        chk("idle_m_wr", m_wr, 0);
        chk("idle_m_addr_hold", m_addr, 14'h0010);
        @(negedge CLK); #1;
        chk("hold_cpu_rvalid", cpu_rvalid, 0);
        chk("hold_cpu_rdata", cpu_rdata, 18'h2A5A5);

        // simultaneous requests: VGA first, CPU next cycle
        @(negedge CLK);
        vga_req = 1'b1; vga_addr = 14'h0100;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h0020;
        #1;
        chk("both_vga_gnt", vga_gnt, 1);
        chk("both_cpu_gnt", cpu_gnt, 0);
        chk("both_m_addr", m_addr, 14'h0100);
        @(negedge CLK);
        vga_req = 1'b0;
        #1;
        chk("both2_cpu_gnt", cpu_gnt, 1);
        chk("both2_vga_rvalid", vga_rvalid, 1);
        chk("both2_vga_rdata", vga_rdata, 18'h3C3C3);
        chk("both2_m_addr", m_addr, 14'h0020);
        @(negedge CLK);
        cpu_req = 1'b0;
        #1;
        chk("both3_cpu_rvalid", cpu_rvalid, 1);
        chk("both3_cpu_rdata", cpu_rdata, 18'h01234);
        chk("both3_vga_rvalid", vga_rvalid, 0);

        // back-to-back VGA reads
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            vga_req  = (k < 4);
            vga_addr = 14'(k % 4);
            #1;
            chk("b2b_vga_gnt", vga_gnt, (k < 4) ? 1 : 0);
            chk("b2b_vga_rvalid", vga_rvalid, (k >= 1 && k <= 4) ? 1 : 0);
            if (k >= 1 && k <= 4) chk("b2b_vga_rdata", vga_rdata, vdat[k-1]);
        end

        // continuous contention: starvation guard or strict priority
        for (int i = 0; i < NCYC; i++) begin
            @(negedge CLK);
            vga_req = 1'b1; vga_addr = 14'h0001;
            cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h0030;
            #1;
            exp_c = GUARD && (i % 5 == 4);
            chk("starve_cpu_gnt", cpu_gnt, exp_c);
            chk("starve_vga_gnt", vga_gnt, !exp_c);
            if (GUARD && i > 0 && (i % 5 == 0)) begin
                chk("starve_cpu_rvalid", cpu_rvalid, 1);
                chk("starve_cpu_rdata", cpu_rdata, 18'h0BEEF);
            end
        end
        @(negedge CLK);
        vga_req = 1'b0; cpu_req = 1'b0;
        #1 chk("starve_end_gnt", vga_gnt | cpu_gnt, 0);

        // reset in the middle of an outstanding VGA read
        @(negedge CLK);
        vga_req = 1'b1; vga_addr = 14'h0001;
        #1 chk("mid_vga_gnt", vga_gnt, 1);
        #2;
        CLR_N = 1'b0; vga_req = 1'b0;
        #1;
        chk("mid_rst_vga_gnt", vga_gnt, 0);
        chk("mid_rst_m_addr", m_addr, 0);
        chk("mid_rst_m_din", m_din, 0);
        chk("mid_rst_m_wr", m_wr, 0);
        chk("mid_rst_vga_rdata", vga_rdata, 0);
        chk("mid_rst_cpu_rdata", cpu_rdata, 0);
        chk("mid_rst_vga_rvalid", vga_rvalid, 0);
        @(negedge CLK);
        CLR_N = 1'b1; vga_req = 1'b1; vga_addr = 14'h0002;
        #1;
        chk("post_rst_vga_rvalid", vga_rvalid, 0);
        chk("post_rst_cpu_rvalid", cpu_rvalid, 0);
        chk("post_rst_vga_gnt", vga_gnt, 1);
        chk("post_rst_m_addr", m_addr, 14'h0002);
        @(negedge CLK);
        vga_req = 1'b0;
        #1;
        chk("post_rst2_vga_rvalid", vga_rvalid, 1);
        chk("post_rst2_vga_rdata", vga_rdata, vdat[2]);
        @(negedge CLK); #1;
        chk("post_rst3_vga_rvalid", vga_rvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA, default 18, giving the memory word width.
REQ-002 The block SHALL have parameter ADDR, default 14, giving the memory address width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, giving the CPU wait-cycle limit under the starvation guard.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port CLR_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port vga_req, input, 1 bit: the VGA fetch requests one read.
REQ-007 The block SHALL have port vga_addr, input, ADDR bits: the VGA read address.
REQ-008 The block SHALL have port vga_gnt, output, 1 bit: the VGA request is accepted this cycle.
REQ-009 The block SHALL have port vga_rvalid, output, 1 bit: vga_rdata is valid.
REQ-010 The block SHALL have port vga_rdata, output, DATA bits: the VGA read data.
REQ-011 The block SHALL have port cpu_req, input, 1 bit: the CPU requests one access.
REQ-012 The block SHALL have port cpu_wr, input, 1 bit: 1 means write, 0 means read.
REQ-013 The block SHALL have port cpu_addr, input, ADDR bits: the CPU address.
REQ-014 The block SHALL have port cpu_din, input, DATA bits: the CPU write data.
REQ-015 The block SHALL have port cpu_gnt, output, 1 bit: the CPU request is accepted this cycle.
REQ-016 The block SHALL have port cpu_rvalid, output, 1 bit: cpu_rdata is valid.
REQ-017 The block SHALL have port cpu_rdata, output, DATA bits: the CPU read data.
REQ-018 The block SHALL have ports m_wr (output, 1 bit), m_addr (output, ADDR bits), m_din (output, DATA bits) and m_dout (input, DATA bits), connecting to one synchronous memory port with 1-cycle read latency.

Function
REQ-019 Each cycle, the block SHALL grant at most one requester; a grant is combinational in the request cycle, with gnt high for exactly that cycle.
REQ-020 Arbitration: only vga_req -> VGA wins; only cpu_req -> CPU wins; both -> VGA wins, except as given in REQ-031.
REQ-021 m_addr, m_wr and m_din SHALL come from the winner; VGA grant forces m_wr=0; with no grant, m_wr=0 and m_addr/m_din hold their last values.
REQ-022 A requester SHALL hold req/addr/wr/din stable until it sees gnt; it may change them or drop req in the cycle after gnt.
REQ-023 A registered owner tag (NONE/VGA/CPU_RD) SHALL record each read grant; in cycle N+1 the owner's rvalid=1 for exactly one cycle and rdata=m_dout.
REQ-024 A CPU write SHALL produce cpu_gnt only, with no cpu_rvalid; the write commits at the grant edge.
REQ-025 rdata outputs SHALL hold their last captured value while rvalid=0.
REQ-026 Back-to-back grants are allowed every cycle, so throughput is 1 access/cycle; a new grant in N+1 and the rvalid from grant N coexist.
REQ-027 A requester with req held continuously SHALL receive a new grant each cycle it wins.

Reset
REQ-028 While CLR_N=0: vga_gnt=cpu_gnt=0, m_wr=0, vga_rvalid=cpu_rvalid=0, vga_rdata=cpu_rdata=0, m_addr=0, m_din=0, owner tag=NONE, starvation counter=0.
REQ-029 Reset asserted mid-operation SHALL discard any outstanding read, so no rvalid appears after reset releases.
REQ-030 After CLR_N rises, the first grant SHALL be possible in the first cycle.

Configuration
REQ-031 With macro ARB_STARVE_GUARD_EN defined: a saturating counter (width clog2(STARVE_MAX+1)) increments each cycle cpu_req=1 and cpu_gnt=0, and clears when cpu_gnt=1 or cpu_req=0; when the counter equals STARVE_MAX and both request, CPU wins.
REQ-032 Without ARB_STARVE_GUARD_EN: strict VGA priority, no counter is present, and CPU starvation under continuous vga_req is permitted.

Verification
REQ-033 Scenario: cpu_req=1, wr=1, addr=0x0010, din=0x2A5A5 -> cpu_gnt high one cycle, m_wr=1, m_addr=0x0010; then a CPU read of 0x0010 -> cpu_rvalid in the next cycle with cpu_rdata=0x2A5A5.
REQ-034 Scenario: vga_req=1 and cpu_req=1 (read 0x0020) in the same cycle, vga_addr=0x0100 -> vga_gnt=1, cpu_gnt=0, m_addr=0x0100; next cycle cpu_gnt=1 and vga_rvalid=1.
REQ-035 Scenario (guard on, STARVE_MAX=4): vga_req held high with cpu_req high -> cpu_gnt=1 on the 5th cycle, counter returns to 0, VGA resumes winning.
REQ-036 Scenario (guard off): the same stimulus for 32 cycles -> cpu_gnt never asserts and vga_gnt=1 in every cycle.
REQ-037 Scenario: a VGA read is granted, then CLR_N=0 before the next edge -> vga_rvalid stays 0, all outputs 0, owner tag NONE after release.
REQ-038 Scenario: VGA reads 0x0000..0x0003 back-to-back -> 4 consecutive vga_gnt, vga_rvalid in 4 consecutive cycles offset by one, with data in address order.
